ce_slicer: RTL and testbench

CE_SLICER -- requirements
Module: ce_slicer

---
 rtl/ce_pkg.sv | 11 +
 rtl/ce_byte_fifo.sv | 61 ++++++
 rtl/ce_slicer.sv | 127 ++++++++++++
 tb/tb_ce_slicer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_pkg.sv
// Shared definitions for the channel-estimation chain: sample format (Q8.32),
// QPSK decision magnitude and error-accumulator width.
package ce_pkg;
    localparam int W      = 40;
    localparam int FRAC   = 32;
    localparam int ACC_W  = 48;
    localparam logic [W-1:0] DEC_AMP = 40'h01_0000_0000;

    typedef logic signed [W-1:0] sample_t;
    typedef logic [ACC_W-1:0]    acc_t;
endpackage

// File: rtl/ce_byte_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO only lands when a pop
// frees the head slot in the same cycle. Head reads as zero when empty.
module ce_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/ce_slicer.sv
// QPSK hard slicer: packs four data symbols per output byte and accumulates
// the L1 distance to the decision points over fixed-length frames.
module ce_slicer #(
    parameter int          W          = ce_pkg::W,
    parameter logic [W-1:0] DEC_AMP   = W'(ce_pkg::DEC_AMP),
    parameter int          FRAME_SYMS = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_pilot,
    input  logic [W-1:0] in_real,
    input  logic [W-1:0] in_imag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_byte,
    output logic         overflow,
    output logic         err_valid,
    output logic [47:0]  err_sum
);
    import ce_pkg::*;

    localparam int CNT_W = $clog2(FRAME_SYMS + 1);
    localparam int E_W   = W + 2;
    localparam int SUM_W = ((E_W > ACC_W) ? E_W : ACC_W) + 1;
    localparam acc_t ACC_MAX = '1;

    logic              accept, bit_r, bit_i;
    logic signed [W:0] dec_r, dec_i, diff_r, diff_i;
    logic [W:0]        abs_r, abs_i;
    logic [E_W-1:0]    err_e;
    logic [SUM_W-1:0]  acc_sum;
    acc_t              acc_sat;

    logic [1:0]       pack_cnt_q, pack_cnt_d;
    logic [5:0]       pack_bits_q, pack_bits_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    acc_t             acc_q, acc_d;
    acc_t             err_sum_q, err_sum_d;
    logic             err_valid_q, err_valid_d;
    logic             overflow_q, overflow_d;

    logic       push, pop, fifo_full, fifo_empty;
    logic [7:0] push_byte;

    assign accept    = in_valid && !in_pilot;
    assign bit_r     = in_real[W-1];
    assign bit_i     = in_imag[W-1];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign overflow  = overflow_q;
    assign err_valid = err_valid_q;
    assign err_sum   = err_sum_q;

    // One extra bit keeps sample-minus-decision exact; its magnitude is below 2^W.
    always_comb begin
        dec_r   = bit_r ? -$signed({1'b0, DEC_AMP}) : $signed({1'b0, DEC_AMP});
        dec_i   = bit_i ? -$signed({1'b0, DEC_AMP}) : $signed({1'b0, DEC_AMP});
        diff_r  = $signed({in_real[W-1], in_real}) - dec_r;
        diff_i  = $signed({in_imag[W-1], in_imag}) - dec_i;
        abs_r   = diff_r[W] ? $unsigned(-diff_r) : $unsigned(diff_r);
        abs_i   = diff_i[W] ? $unsigned(-diff_i) : $unsigned(diff_i);
        err_e   = E_W'(abs_r) + E_W'(abs_i);
        acc_sum = SUM_W'(acc_q) + SUM_W'(err_e);
        acc_sat = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
    end

    always_comb begin
        pack_cnt_d  = pack_cnt_q;
        pack_bits_d = pack_bits_q;
        sym_cnt_d   = sym_cnt_q;
        acc_d       = acc_q;
        err_sum_d   = err_sum_q;
        err_valid_d = 1'b0;
        push        = 1'b0;
        push_byte   = {pack_bits_q, bit_r, bit_i};
        if (accept) begin
            pack_cnt_d  = pack_cnt_q + 2'd1;
            pack_bits_d = {pack_bits_q[3:0], bit_r, bit_i};
            push        = (pack_cnt_q == 2'd3);
            if (sym_cnt_q == CNT_W'(FRAME_SYMS - 1)) begin
                err_sum_d   = acc_sat;
                err_valid_d = 1'b1;
                acc_d       = '0;
                sym_cnt_d   = '0;
            end else begin
                acc_d     = acc_sat;
                sym_cnt_d = sym_cnt_q + 1'b1;
            end
        end
        overflow_d = overflow_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_cnt_q  <= '0;
            pack_bits_q <= '0;
            sym_cnt_q   <= '0;
            acc_q       <= '0;
            err_sum_q   <= '0;
            err_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pack_cnt_q  <= pack_cnt_d;
            pack_bits_q <= pack_bits_d;
            sym_cnt_q   <= sym_cnt_d;
            acc_q       <= acc_d;
            err_sum_q   <= err_sum_d;
            err_valid_q <= err_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    ce_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_byte),
        .pop      (pop),
        .head     (out_byte),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule

// File: tb/tb_ce_slicer.sv
// Scoreboard bench for ce_slicer: directed symbol sequences push expected bytes
// and error sums into queues; a negedge monitor pops and compares them.
module tb_ce_slicer;
    localparam logic [39:0] POS  = 40'h01_0000_0000;
    localparam logic [39:0] NEG  = 40'hFF_0000_0000;
    localparam logic [39:0] R125 = 40'h01_4000_0000;
    localparam logic [47:0] ESUM = 48'h4_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_pilot = 1'b0;
    logic [39:0] in_real = '0;
    logic [39:0] in_imag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        overflow;
    logic        err_valid;
    logic [47:0] err_sum;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int bytes_popped = 0;
    int base;
    logic prev_err = 1'b0;
    logic [7:0]  exp_bytes [$];
    logic [47:0] exp_errs [$];

    ce_slicer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_pilot (in_pilot),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_byte (out_byte),
        .overflow (overflow),
        .err_valid(err_valid),
        .err_sum  (err_sum)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_symbol(input logic [39:0] r, input logic [39:0] i, input logic pilot);
        in_valid = 1'b1;
        in_pilot = pilot;
        in_real  = r;
        in_imag  = i;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_pilot = 1'b0;
    endtask

    task automatic apply_pair(input logic [1:0] b);
        apply_symbol(b[1] ? NEG : POS, b[0] ? NEG : POS, 1'b0);
    endtask

    task automatic apply_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            apply_pair(b[7-2*k -: 2]);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (out_valid && n < 20) begin
            idle(1);
            n++;
        end
        check_output({name, "_out_valid_low"}, 64'(out_valid), 64'd0);
        check_output({name, "_queue_empty"}, 64'(exp_bytes.size()), 64'd0);
    endtask

    // Monitor: compares every accepted byte and every error pulse against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                bytes_popped++;
                if (exp_bytes.size() == 0) begin
                    check_output("byte_unexpected", 64'(out_byte), 64'hDEAD);
                end else begin
                    check_output("byte_value", 64'(out_byte), 64'(exp_bytes.pop_front()));
                end
            end
            if (err_valid) begin
                err_pulses++;
                check_output("err_pulse_width", 64'(prev_err), 64'd0);
                if (exp_errs.size() == 0) begin
                    check_output("err_unexpected", 64'(err_sum), 64'hDEAD);
                end else begin
                    check_output("err_sum_value", 64'(err_sum), 64'(exp_errs.pop_front()));
                end
            end
        end
        prev_err = err_valid;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle(2);
        apply_reset();
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_byte", 64'(out_byte), 64'd0);
        check_output("rst_overflow", 64'(overflow), 64'd0);
        check_output("rst_err_valid", 64'(err_valid), 64'd0);
        check_output("rst_err_sum", 64'(err_sum), 64'd0);

        // Basic packing: 00 10 01 11 -> 0x27, visible one cycle after 4th symbol
        out_ready = 1'b1;
        apply_symbol(POS, POS, 1'b0);
        apply_symbol(NEG, POS, 1'b0);
        apply_symbol(POS, NEG, 1'b0);
        check_output("pack_not_early", 64'(out_valid), 64'd0);
        exp_bytes.push_back(8'h27);
        apply_symbol(NEG, NEG, 1'b0);
        check_output("pack_valid_latency", 64'(out_valid), 64'd1);
        wait_drain("pack");

        // Pilots interleaved must not disturb the byte
        apply_reset();
        apply_symbol(POS, POS, 1'b0);
        apply_symbol(NEG, NEG, 1'b1);
        apply_symbol(NEG, POS, 1'b0);
        apply_symbol(NEG, NEG, 1'b1);
        apply_symbol(POS, NEG, 1'b0);
        apply_symbol(NEG, NEG, 1'b1);
        exp_bytes.push_back(8'h27);
        apply_symbol(NEG, NEG, 1'b0);
        apply_symbol(NEG, NEG, 1'b1);
        idle(3);
        check_output("pilot_single_byte", 64'(out_valid), 64'd0);
        check_output("pilot_queue_empty", 64'(exp_bytes.size()), 64'd0);

        // Error metric frame: 16 x |0.25| -> 4.0
        apply_reset();
        base = err_pulses;
        for (int k = 0; k < 15; k++) begin
            if (k % 4 == 3) exp_bytes.push_back(8'h00);
            apply_symbol(R125, POS, 1'b0);
        end
        check_output("err_no_early_pulse", 64'(err_pulses - base), 64'd0);
        exp_bytes.push_back(8'h00);
        exp_errs.push_back(ESUM);
        apply_symbol(R125, POS, 1'b0);
        check_output("err_valid_rise", 64'(err_valid), 64'd1);
        idle(1);
        check_output("err_valid_fall", 64'(err_valid), 64'd0);
        idle(3);
        check_output("err_sum_hold", 64'(err_sum), 64'(ESUM));
        check_output("err_single_pulse", 64'(err_pulses - base), 64'd1);
        wait_drain("err");

        // Overflow: consumer stalled, 5 bytes offered, 5th dropped
        apply_reset();
        out_ready = 1'b0;
        apply_byte(8'h27);
        apply_byte(8'h1B);
        apply_byte(8'hE4);
        exp_bytes.push_back(8'h27);
        exp_bytes.push_back(8'h1B);
        exp_bytes.push_back(8'hE4);
        exp_bytes.push_back(8'h00);
        exp_errs.push_back(48'h0);
        apply_byte(8'h00);
        check_output("ovf_not_yet", 64'(overflow), 64'd0);
        check_output("ovf_full_valid", 64'(out_valid), 64'd1);
        apply_byte(8'hFF);
        check_output("ovf_set", 64'(overflow), 64'd1);
        base = bytes_popped;
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check_output("ovf_drain_count", 64'(bytes_popped - base), 64'd4);
        check_output("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with simultaneous pop and push: nothing lost
        apply_reset();
        check_output("ovf_cleared", 64'(overflow), 64'd0);
        out_ready = 1'b0;
        base = bytes_popped;
        apply_byte(8'h1B);
        apply_byte(8'h27);
        apply_byte(8'hE4);
        exp_bytes.push_back(8'h1B);
        exp_bytes.push_back(8'h27);
        exp_bytes.push_back(8'hE4);
        exp_bytes.push_back(8'h93);
        exp_errs.push_back(48'h0);
        apply_byte(8'h93);
        apply_pair(2'b11);
        apply_pair(2'b00);
        apply_pair(2'b01);
        exp_bytes.push_back(8'hC6);
        out_ready = 1'b1;
        apply_pair(2'b10);
        out_ready = 1'b0;
        check_output("pp_no_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        wait_drain("pp_drain");
        check_output("pp_pop_count", 64'(bytes_popped - base), 64'd5);

        // Reset mid-byte, with a symbol offered during reset
        apply_reset();
        apply_pair(2'b11);
        apply_pair(2'b11);
        in_valid = 1'b1;
        in_real  = POS;
        in_imag  = NEG;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_bytes.push_back(8'h1B);
        apply_byte(8'h1B);
        wait_drain("rst_byte");

        // Reset mid-frame discards the partial error sum
        for (int k = 0; k < 7; k++) begin
            if (k == 3) exp_bytes.push_back(8'h00);
            apply_symbol(R125, POS, 1'b0);
        end
        check_output("rst_frame_queue", 64'(exp_bytes.size()), 64'd0);
        apply_reset();
        base = err_pulses;
        for (int k = 0; k < 15; k++) begin
            if (k % 4 == 3) exp_bytes.push_back(8'h00);
            apply_symbol(R125, POS, 1'b0);
        end
        check_output("rst_frame_no_early", 64'(err_pulses - base), 64'd0);
        exp_bytes.push_back(8'h00);
        exp_errs.push_back(ESUM);
        apply_symbol(R125, POS, 1'b0);
        idle(2);
        check_output("rst_frame_pulse", 64'(err_pulses - base), 64'd1);
        wait_drain("rst_frame");
        check_output("err_queue_empty", 64'(exp_errs.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
